pipeline_ctrl_unit: RTL
=======================

// Module: pipeline_ctrl_unit
// PURPOSE
//  Parametrised central stall/flush controller for the superscalar pipeline. Maps N stall
//  sources onto per-stage stall/flush controls and inserts bubbles below the stall boundary.
//  Sequences branch/exception recovery with a registered FSM and a front-end flush window.
//  Selects the PC source and flags a stall deadlock via a watchdog.
// PARAMETERS
//  NUM_STAGES     6        pipeline registers controlled; index 0 = IF, ascending downstream
//  NUM_STALL_SRC  2        stall sources (src0 = ROB full, src1 = rename fail by default)
//  STALL_MASK     {6'b011111,6'b000111}  per source, bit i=1 -> source stalls stage i
//  FLUSH_CYCLES   2        cycles stage 0 stays flushed after a redirect (range 1..15)
//  WDOG_LIMIT     1024     consecutive stalled no-commit cycles before deadlock
//  PC_SEL_W       3        width of pc_sel
// PORTS
//  clk           in   1              clock
//  rst           in   1              asynchronous reset, active-high
//  stall_src     in   NUM_STALL_SRC  raw stall requests
//  inst_ready    in   1              I-fetch data valid
//  branch_occur  in   1              resolved mispredict, redirect this cycle
//  exception     in   1              precise exception at commit, redirect this cycle
//  commit        in   1              >=1 instruction retired this cycle
//  inst_req      out  1              I-fetch request enable
//  pc_sel        out  PC_SEL_W       0 seq, 1 branch target, 2 exception vector
//  stage_stall   out  NUM_STAGES     per-stage hold
//  stage_flush   out  NUM_STAGES     per-stage clear (bubble)
//  branch_flush  out  1              redirect in progress this cycle
//  recovering    out  1              FSM in RECOVER
//  deadlock      out  1              watchdog tripped (sticky)
// BEHAVIOUR
//  - FSM states WARMUP, RUN, RECOVER (state, counter, watchdog registered; outputs comb).
//  - While rst=1 and in WARMUP (1 cycle after release): stage_flush all 1, stage_stall 0,
//    inst_req 0, pc_sel 0, branch_flush 0, recovering 0, deadlock 0. WARMUP -> RUN.
//  - Redirect cycle (RUN or RECOVER, branch_occur|exception): stage_flush all 1, stage_stall 0,
//    branch_flush 1, inst_req 0; pc_sel 2 if exception (priority) else 1; next RECOVER with
//    cnt=FLUSH_CYCLES-1. A redirect inside RECOVER reloads cnt (zero-cycle redirect latency).
//  - RECOVER, no redirect: stage_flush[0]=1, others from stall rule, inst_req 0, pc_sel 0;
//    cnt==0 -> RUN else cnt--.
//  - RUN, no redirect: s[i] = |(stall_src & STALL_MASK column i); stage_stall[i]=s[i],
//    stage_stall[0] |= !inst_ready; stage_flush[i]=s[i-1]&!s[i] for i>=1 (bubble), [0]=0;
//    inst_req = !(|stall_src); pc_sel 0.
//  - Flush always dominates stall on the same stage; stall never asserted with flush.
//  - Watchdog: wd++ (saturating at WDOG_LIMIT) when |stall_src & !commit, cleared to 0 on
//    commit or any redirect; wd==WDOG_LIMIT sets deadlock; deadlock clears on commit/reset.
//  - Reset mid-RECOVER: immediate return to reset values, then WARMUP.
// CONFIGURATION
//  PCU_PERF_CNT_EN defined: adds outputs perf_stall_cyc[31:0] (cycles with |stage_stall) and
//  perf_redirects[31:0] (redirect cycles), both wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Processor_Pkg: pcu_state_e {WARMUP,RUN,RECOVER}; PCSEL_SEQ/BR/EXC constants;
//  stage_ctrl_t {stall,flush} for stage-indexed views.
//  Sub-module pcu_watchdog (counter + sticky flag); mask decode stays inline.
// TESTING
//  1 rst 1->0: cycle0 stage_flush=6'h3F, inst_req=0; cycle1 RUN, flush=0, inst_req=1.
//  2 RUN stall_src=2'b10: stall=6'h07, flush=6'h08, inst_req=0; 2'b01: stall=6'h1F, flush=6'h20.
//  3 branch_occur 1 cycle: pc_sel=1, flush=6'h3F; next 2 cycles flush[0]=1, recovering=1; then RUN.
//  4 branch_occur+exception same cycle: pc_sel=2; branch again in RECOVER -> cnt reloaded, 2 more.
//  5 stall_src=2'b01, no commit for 1024 cycles -> deadlock=1; one commit -> deadlock=0, wd=0.
//  6 rst asserted mid-RECOVER -> outputs at reset values same cycle; perf counters 0 (macro on).

Source files
------------

// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_unit_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } pcu_state_e;

    // PC source encodings driven on pc_sel
    localparam int PCSEL_SEQ = 0;
    localparam int PCSEL_BR  = 1;
    localparam int PCSEL_EXC = 2;

    // Width of the recovery window counter (FLUSH_CYCLES is limited to 1..15)
    localparam int CNT_W = 4;

    // Per-stage control view
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_unit_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles without a commit and raises a sticky deadlock flag.
// Latency: deadlock rises on the same edge the counter reaches WDOG_LIMIT.
// Backpressure: none; pure monitor. Ports: clk, rst, stall_any, commit, redirect -> deadlock.
module pcu_watchdog #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any,
    input  logic commit,
    input  logic redirect,
    output logic deadlock
);
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] LIMIT = WD_W'(WDOG_LIMIT);

    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_nxt;

    // Counter holds (rather than clears) on cycles that neither stall nor commit.
    always_comb begin
        wd_nxt = wd;
        if (commit || redirect) begin
            wd_nxt = '0;
        end else if (stall_any && (wd != LIMIT)) begin
            wd_nxt = wd + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd       <= '0;
            deadlock <= 1'b0;
        end else begin
            wd <= wd_nxt;
            // Only a commit releases the flag; a redirect clears the count but not the flag.
            if (commit) begin
                deadlock <= 1'b0;
            end else if (wd_nxt == LIMIT) begin
                deadlock <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush controller: maps stall sources to per-stage stall/flush, sequences redirect recovery, selects PC source.
// Latency: stage controls are combinational from inputs and registered FSM state; redirects take effect the same cycle.
// Backpressure: stalls hold stages at/above the stall boundary and bubble the stage below; optional perf counters via PCU_PERF_CNT_EN.
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int NUM_STAGES    = 6,
    parameter int NUM_STALL_SRC = 2,
    // Ascending outer range: the leftmost mask in the literal belongs to source 0.
    parameter logic [0:NUM_STALL_SRC-1][NUM_STAGES-1:0] STALL_MASK = {6'b011111, 6'b000111},
    parameter int FLUSH_CYCLES  = 2,
    parameter int WDOG_LIMIT    = 1024,
    parameter int PC_SEL_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_STALL_SRC-1:0] stall_src,
    input  logic                     inst_ready,
    input  logic                     branch_occur,
    input  logic                     exception,
    input  logic                     commit,
    output logic                     inst_req,
    output logic [PC_SEL_W-1:0]      pc_sel,
    output logic [NUM_STAGES-1:0]    stage_stall,
    output logic [NUM_STAGES-1:0]    stage_flush,
    output logic                     branch_flush,
    output logic                     recovering,
    output logic                     deadlock
`ifdef PCU_PERF_CNT_EN
    ,
    output logic [31:0]              perf_stall_cyc,
    output logic [31:0]              perf_redirects
`endif
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    pcu_state_e                state_q;
    pcu_state_e                state_nxt;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_nxt;
    logic                      redirect;
    logic                      stall_any;
    logic [NUM_STAGES-1:0]     s;
    stage_ctrl_t [NUM_STAGES-1:0] ctrl;

    assign stall_any = |stall_src;
    assign redirect  = ((state_q == RUN) || (state_q == RECOVER)) && (branch_occur || exception);

    // Stage i is stalled if any active source has bit i set in its mask.
    always_comb begin
        s = '0;
        for (int j = 0; j < NUM_STALL_SRC; j++) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                s[i] = s[i] | (stall_src[j] & STALL_MASK[j][i]);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic; a redirect inside RECOVER restarts the flush window.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            WARMUP: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = CNT_RELOAD;
                end
            end
            RECOVER: begin
                if (redirect) begin
                    cnt_nxt = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nxt = WARMUP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        inst_req     = 1'b0;
        pc_sel       = PC_SEL_W'(PCSEL_SEQ);
        branch_flush = 1'b0;
        ctrl         = '0;
        case (state_q)
            RUN, RECOVER: begin
                if (redirect) begin
                    branch_flush = 1'b1;
                    pc_sel       = exception ? PC_SEL_W'(PCSEL_EXC) : PC_SEL_W'(PCSEL_BR);
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        ctrl[i].flush = 1'b1;
                    end
                end else begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        ctrl[i].stall = s[i];
                    end
                    // Bubble into the first stage below the stall boundary.
                    for (int i = 1; i < NUM_STAGES; i++) begin
                        ctrl[i].flush = s[i-1] & ~s[i];
                    end
                    ctrl[0].stall = s[0] | ~inst_ready;
                    if (state_q == RECOVER) begin
                        ctrl[0].flush = 1'b1;
                    end else begin
                        inst_req = ~stall_any;
                    end
                end
            end
            default: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    ctrl[i].flush = 1'b1;
                end
            end
        endcase
        // Flush dominates stall on the same stage.
        for (int i = 0; i < NUM_STAGES; i++) begin
            ctrl[i].stall = ctrl[i].stall & ~ctrl[i].flush;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_stall[i] = ctrl[i].stall;
            stage_flush[i] = ctrl[i].flush;
        end
    end

    assign recovering = (state_q == RECOVER);

    pcu_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .stall_any (stall_any),
        .commit    (commit),
        .redirect  (redirect),
        .deadlock  (deadlock)
    );

`ifdef PCU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_redirects <= '0;
        end else begin
            if (|stage_stall) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
